// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rv_pkg                                                     |
// | Shared RISC-V opcode class constants and datapath width defaults.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rv_pkg;

  // Default datapath and register-address widths
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  // Major opcode class, taken from opcode[6:2]
  typedef logic [4:0] opclass_t;

  localparam opclass_t OP_LOAD   = 5'b00000;
  localparam opclass_t OP_IMM    = 5'b00100;
  localparam opclass_t OP_AUIPC  = 5'b00101;
  localparam opclass_t OP_STORE  = 5'b01000;
  localparam opclass_t OP_REG    = 5'b01100;
  localparam opclass_t OP_LUI    = 5'b01101;
  localparam opclass_t OP_BRANCH = 5'b11000;
  localparam opclass_t OP_JALR   = 5'b11001;
  localparam opclass_t OP_JAL    = 5'b11011;
  localparam opclass_t OP_SYSTEM = 5'b11100;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/wb_opclass_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_opclass_decode                                          |
// | Flags opcodes whose instruction writes the destination register.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module wb_opclass_decode
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_writes_rd
);

  // The low two opcode bits are always 2'b11 for 32-bit encodings and carry
  // no class information.
  logic w_unused_low_bits;
  assign w_unused_low_bits = ^i_opcode[1:0];

  // Only loads, ALU ops, upper-immediates and jumps produce an rd value
  always_comb begin
    case (opclass_t'(i_opcode[6:2]))
      OP_LOAD, OP_IMM, OP_REG, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR:       o_writes_rd = 1'b1;
      default:                         o_writes_rd = 1'b0;
    endcase
  end

endmodule : wb_opclass_decode
`default_nettype wire

// File: rtl/rd_writeback_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rd_writeback_buffer                                        |
// | Queues register writebacks, drains one per cycle into the register   |
// | file and forwards the youngest pending value to operand readers.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rd_writeback_buffer
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [AW-1:0]            in_rd,
  input  logic [XLEN-1:0]          in_data,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [AW-1:0]            wr_addr,
  output logic [XLEN-1:0]          wr_data,
  input  logic [AW-1:0]            fwd_addr,
  output logic                     fwd_hit,
  output logic [XLEN-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [DEPTH-1:0]    r_valid;
  logic [AW-1:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]     r_data [DEPTH];
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [CW-1:0]       r_count;

  logic                w_writes_rd;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;

  wb_opclass_decode u_decode (
    .i_opcode    (in_opcode),
    .o_writes_rd (w_writes_rd)
  );

  // No full-bypass: a pop in the same cycle does not open a full buffer
  assign in_ready = (r_count != c_full);
  assign w_empty  = (r_count == '0);
  assign wr_en    = !w_empty;
  assign count    = r_count;

  // Non-writing results and writes to x0 are accepted but dropped
  assign w_push = in_valid && in_ready && w_writes_rd && (in_rd != '0);
  assign w_pop  = wr_en && wr_ready;

  assign wr_addr = w_empty ? '0 : r_rd[r_head];
  assign wr_data = w_empty ? '0 : r_data[r_head];

  // Pointers, occupancy and entry valid bits; reset flushes pending writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= in_rd;
      r_data[r_tail] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest one
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[r_head + PW'(k)] && (r_rd[r_head + PW'(k)] == fwd_addr) &&
          (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[r_head + PW'(k)];
      end
    end
  end

endmodule : rd_writeback_buffer
`default_nettype wire

// File: tb/tb_rd_writeback_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rd_writeback_buffer                                     |
// | Self-checking bench for rd_writeback_buffer against a queue model.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_rd_writeback_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      in_opcode = 7'b0;
  logic [AW-1:0]   in_rd = '0;
  logic [XLEN-1:0] in_data = '0;
  logic            wr_en;
  logic            wr_ready = 1'b0;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   fwd_addr = '0;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [2:0]      count;

  rd_writeback_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [6:0] ops [10];

  function automatic bit writes_rd(input logic [6:0] op);
    case (op[6:2])
      5'b00000, 5'b00100, 5'b01100, 5'b01101,
      5'b00101, 5'b11011, 5'b11001: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every output against what the pending-write queue implies
  task automatic compare_all();
    int n;
    bit hit;
    logic [XLEN-1:0] fd;
    n   = q.size();
    hit = 1'b0;
    fd  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!hit && fwd_addr != 0 && q[i].rd == fwd_addr) begin
        hit = 1'b1;
        fd  = q[i].data;
      end
    end
    check("in_ready", in_ready, (n != DEPTH));
    check("wr_en",    wr_en,    (n != 0));
    check("wr_addr",  wr_addr,  (n != 0) ? q[0].rd : '0);
    check("wr_data",  wr_data,  (n != 0) ? q[0].data : '0);
    check("fwd_hit",  fwd_hit,  hit);
    check("fwd_data", fwd_data, fd);
    check("count",    count,    n);
  endtask

  // Edge behaviour of the model: pop the head, then accept the input
  task automatic model_update();
    bit acc;
    bit pop;
    if (!rst) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() != DEPTH);
      pop = (q.size() != 0) && wr_ready;
      if (pop) void'(q.pop_front());
      if (acc && writes_rd(in_opcode) && in_rd != 0)
        q.push_back('{rd: in_rd, data: in_data});
    end
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [AW-1:0] rd,
                       input logic [XLEN-1:0] d);
    in_valid  = v;
    in_opcode = op;
    in_rd     = rd;
    in_data   = d;
  endtask

  initial begin
    ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b0100011, 7'b1100011, 7'b1110011};

    // Reset held with a valid input presented
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 7'b0110011, 5'd5, 32'h1234);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_in_ready", in_ready, 1);
      check("rst_wr_en",    wr_en,    0);
      check("rst_count",    count,    0);
      check("rst_fwd_hit",  fwd_hit,  0);
      advance();
    end
    rst = 1'b1;

    // Single write, then forward, then drain
    wr_ready = 1'b0;
    drive(1'b1, 7'b0110011, 5'd5, 32'hDEADBEEF);
    settle(); advance();
    drive(1'b0, 7'b0, 5'd0, 32'h0);
    fwd_addr = 5'd5;
    settle();
    check("single_wr_en",    wr_en,    1);
    check("single_wr_addr",  wr_addr,  5);
    check("single_wr_data",  wr_data,  32'hDEADBEEF);
    check("single_count",    count,    1);
    check("single_fwd_hit",  fwd_hit,  1);
    check("single_fwd_data", fwd_data, 32'hDEADBEEF);
    wr_ready = 1'b1;
    settle();
    check("popping_fwd_hit", fwd_hit, 1);
    advance();
    settle();
    check("drained_count", count, 0);
    check("drained_wr_en", wr_en, 0);

    // Non-writing results and rd=0 are dropped
    wr_ready = 1'b0;
    drive(1'b1, 7'b0100011, 5'd7, 32'h7);  settle(); advance();
    drive(1'b1, 7'b1100011, 5'd3, 32'h3);  settle(); advance();
    drive(1'b1, 7'b0010011, 5'd0, 32'h9);  settle(); advance();
    drive(1'b0, 7'b0, 5'd0, 32'h0);
    settle();
    check("filter_count", count, 0);
    check("filter_wr_en", wr_en, 0);

    // Fill, backpressure, one pop, then the held write enters
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 7'b0000011, 5'(i), 32'(i * 16'h1111));
      settle(); advance();
    end
    drive(1'b1, 7'b0110111, 5'd5, 32'h55);
    settle();
    check("full_count",    count,    4);
    check("full_in_ready", in_ready, 0);
    advance();
    settle();
    check("held_count", count, 4);
    wr_ready = 1'b1;
    settle();
    check("full_pop_no_bypass", in_ready, 0);
    advance();
    wr_ready = 1'b0;
    settle();
    check("after_pop_count",    count,    3);
    check("after_pop_in_ready", in_ready, 1);
    advance();
    drive(1'b0, 7'b0, 5'd0, 32'h0);
    settle();
    check("fifth_count", count, 4);
    wr_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      settle();
      check("drain_order", wr_addr, i);
      advance();
    end
    wr_ready = 1'b0;

    // Youngest duplicate wins forwarding; drain keeps program order
    drive(1'b1, 7'b0010011, 5'd9, 32'h11); settle(); advance();
    drive(1'b1, 7'b0010011, 5'd9, 32'h22); settle(); advance();
    drive(1'b0, 7'b0, 5'd0, 32'h0);
    fwd_addr = 5'd9;
    settle();
    check("youngest_fwd", fwd_data, 32'h22);
    wr_ready = 1'b1;
    settle();
    check("dup_first",  wr_data, 32'h11);
    advance();
    settle();
    check("dup_second", wr_data, 32'h22);
    advance();
    wr_ready = 1'b0;

    // Steady push+pop at occupancy 2 across pointer wrap
    drive(1'b1, 7'b0110011, 5'd10, 32'hA0); settle(); advance();
    drive(1'b1, 7'b0110011, 5'd11, 32'hB0); settle(); advance();
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 7'b0110011, 5'(12 + i), 32'(16'hC000 + i));
      settle();
      check("pushpop_count", count, 2);
      advance();
    end
    drive(1'b0, 7'b0, 5'd0, 32'h0);
    wr_ready = 1'b0;
    fwd_addr = 5'd19;
    settle();
    check("pre_reset_fwd_hit", fwd_hit, 1);
    check("pre_reset_count",   count,   2);

    // Asynchronous reset between edges flushes everything at once
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    check("async_rst_count",   count,   0);
    check("async_rst_wr_en",   wr_en,   0);
    check("async_rst_fwd_hit", fwd_hit, 0);
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1'b0;
        q.delete();
      end else begin
        rst = 1'b1;
      end
      drive(1'($urandom_range(3) != 0),
            ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(9)],
            5'($urandom_range(7)), $urandom);
      wr_ready = ($urandom_range(2) != 0);
      fwd_addr = 5'($urandom_range(7));
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rd_writeback_buffer
`default_nettype wire

// File: doc/rd_writeback_buffer.md
Name: rd_writeback_buffer

Overview:
Write-side counterpart of the operand read path. It accepts completed results (opcode, rd, data) from execute/load with a valid/ready handshake. Writes that actually target a register are queued in a small FIFO and drained one per cycle into the register file write port. Queued values are forwarded back to operand readers so that a pending write is never missed by a following read.

Parameters:
XLEN, 32, datapath width
DEPTH, 4, FIFO entries (power of two, >=2)
AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
in_valid  in  1  result presented
in_ready  out  1  buffer can accept this cycle
in_opcode  in  7  opcode of producing instruction
in_rd  in  AW  destination register
in_data  in  XLEN  result value
wr_en  out  1  register-file write request (head valid)
wr_ready  in  1  register file accepts write this cycle
wr_addr  out  AW  head destination
wr_data  out  XLEN  head value
fwd_addr  in  AW  operand address being read
fwd_hit  out  1  fwd_addr matches a queued entry
fwd_data  out  XLEN  youngest matching queued value
count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst=0, async): head/tail pointers = 0, count = 0, all entry valid bits cleared. Outputs: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, fwd_hit=0, fwd_data=0. A reset asserted mid-operation flushes all pending writes; they are lost.
- Write-class decode, combinational on in_opcode:
  - Writes rd: opcode[6:2] = 00000 (load), 00100 (ALU-imm), 01100 (ALU-reg), 01101 (LUI), 00101 (AUIPC), 11011 (JAL), 11001 (JALR).
  - Everything else does not write rd: store, branch, system, unknown.
- Accept: handshake fires when in_valid && in_ready. in_ready = (count != DEPTH).
  - If the accepted result is write-class and in_rd != 0, it is enqueued at the tail on the same edge.
  - Otherwise it is accepted and discarded; no state changes.
- Drain: wr_en = (count != 0); wr_addr and wr_data are driven from the head entry combinationally. Pop occurs on an edge where wr_en && wr_ready. When empty, wr_addr and wr_data = 0.
- Throughput: one enqueue and one pop in the same cycle is legal; count is unchanged. When full, in_ready = 0 even if a pop is occurring that cycle (no full-bypass). Enqueue-to-wr_en latency is 1 cycle.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH and never exceeds it.
- Forwarding, combinational:
  - Scan valid entries from tail-1 back to head. fwd_hit=1 when any valid entry has rd == fwd_addr and fwd_addr != 0.
  - fwd_data = data of the youngest such entry; otherwise fwd_data = 0.
  - An entry popped on the current edge still forwards during that cycle.
  - An incoming in_* result is not forwarded until it is enqueued.
- Duplicate rd values in the queue are legal. Writes drain in order, so the final register value is the youngest.

Decomposition:
- Shared package `rv_pkg`: opcode[6:2] class constants (OP_LOAD, OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_STORE, OP_BRANCH), plus XLEN and AW defaults.
- One sub-module, `wb_opclass_decode`: in_opcode -> writes_rd. It is reused by the operand-select logic.
- The FIFO and forward scan stay inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=1, wr_en=0, count=0, fwd_hit=0 throughout.
- Single write: opcode 0110011, rd=5, data=0xDEADBEEF accepted with wr_ready=0 -> next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, count=1. With fwd_addr=5 -> fwd_hit=1, fwd_data=0xDEADBEEF. Raise wr_ready -> count=0 and wr_en=0 after the edge.
- Filtering: store 0100011 rd=7, branch 1100011 rd=3, and ALU-imm 0010011 rd=0 each accepted -> count stays 0, wr_en stays 0.
- Full/backpressure: wr_ready=0, enqueue 4 writes rd=1..4 -> count=4, in_ready=0. A 5th in_valid is held and not accepted. One pop -> in_ready=1 next cycle, and the 5th write enqueues.
- Youngest forwarding: enqueue rd=9 data=0x11, then rd=9 data=0x22 -> fwd_addr=9 gives fwd_data=0x22. Drain -> wr_data sequence 0x11 then 0x22.
- Simultaneous push/pop plus mid-op reset: at count=2, push and pop on the same edge -> count=2 and pointers wrap correctly across 8 such cycles. Then pulse rst=0 between edges -> immediately count=0, wr_en=0, fwd_hit=0.
